// File: rtl/qspi_distributor.sv
// QSPI beat collector that programs a key into every encrypter lane and then
// distributes packed data words round-robin across lanes with a rotation tag.
module qspi_distributor #(
  parameter int NUM_ENC = 4,
  parameter int BUS_W   = 4,
  parameter int ENC_W   = 32,
  parameter int KEY_W   = 128,
  parameter int ROT_MAX = 4,
  parameter int ROT_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     qspi_cs,
  input  logic                     qspi_valid,
  input  logic [BUS_W-1:0]         qspi_data,
  output logic                     qspi_ready,
  input  logic                     prog,
  output logic [NUM_ENC*ENC_W-1:0] enc_data,
  output logic [NUM_ENC*ROT_W-1:0] enc_rot,
  output logic [NUM_ENC-1:0]       enc_prog,
  output logic [NUM_ENC-1:0]       enc_valid,
  input  logic [NUM_ENC-1:0]       enc_ready,
  output logic                     key_loaded,
  output logic                     frame_err,
  output logic [2:0]               state_out
);

  localparam int KEY_BEATS = KEY_W / BUS_W;
  localparam int PKT_BEATS = ENC_W / BUS_W;
  localparam int KEY_WORDS = KEY_W / ENC_W;
  localparam int CNT_W     = (KEY_BEATS > 1) ? $clog2(KEY_BEATS) : 1;
  localparam int KW_W      = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int IDX_W     = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_RX    = 3'd1,
    KEY_PROG  = 3'd2,
    KEY_WAIT  = 3'd3,
    DATA_RX   = 3'd4,
    DATA_PUSH = 3'd5
  } state_t;

  state_t                   state_q, state_d, eff;
  logic                     cs_q;
  logic                     err_block_q, err_block_d;
  logic                     ready_q, ready_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [KW_W-1:0]          kw_q, kw_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ROT_W-1:0]         rot_q, rot_d;
  logic [KEY_W-1:0]         shadow_q, shadow_d;
  logic [KEY_W-1:0]         key_q, key_d;
  logic [ENC_W-1:0]         pkt_q, pkt_d;
  logic [NUM_ENC*ENC_W-1:0] enc_data_q, enc_data_d;
  logic [NUM_ENC*ROT_W-1:0] enc_rot_q, enc_rot_d;
  logic [NUM_ENC-1:0]       enc_prog_q, enc_prog_d;
  logic [NUM_ENC-1:0]       enc_valid_q, enc_valid_d;
  logic                     key_loaded_q, key_loaded_d;
  logic                     frame_err_q, frame_err_d;

  logic cs_rise, beat;
  assign cs_rise = qspi_cs & ~cs_q;
  assign beat    = qspi_cs & qspi_valid & ready_q;

  always_comb begin
    state_d      = state_q;
    err_block_d  = err_block_q;
    cnt_d        = cnt_q;
    kw_d         = kw_q;
    idx_d        = idx_q;
    rot_d        = rot_q;
    shadow_d     = shadow_q;
    key_d        = key_q;
    pkt_d        = pkt_q;
    enc_data_d   = enc_data_q;
    enc_rot_d    = enc_rot_q;
    enc_prog_d   = enc_prog_q;
    enc_valid_d  = enc_valid_q;
    key_loaded_d = key_loaded_q;
    frame_err_d  = 1'b0;
    eff          = state_q;

    // A frame start re-targets this cycle into the receive state so that a
    // beat arriving together with the chip-select rise is not lost.
    if (state_q == IDLE) begin
      if (err_block_q) begin
        if (!qspi_cs) err_block_d = 1'b0;
      end else if (cs_rise) begin
        if (prog) begin
          eff      = KEY_RX;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (key_loaded_q) begin
          eff   = DATA_RX;
          cnt_d = '0;
          pkt_d = '0;
          idx_d = '0;
          rot_d = '0;
        end else begin
          frame_err_d = 1'b1;
          err_block_d = 1'b1;
        end
      end
    end
    state_d = eff;

    case (eff)
      KEY_RX: begin
        if (!qspi_cs) begin
          state_d     = IDLE;
          shadow_d    = '0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else if (beat) begin
          shadow_d[int'(cnt_d)*BUS_W +: BUS_W] = qspi_data;
          if (cnt_d == CNT_W'(KEY_BEATS-1)) begin
            state_d    = KEY_PROG;
            key_d      = shadow_d;
            cnt_d      = '0;
            kw_d       = '0;
            enc_data_d = {NUM_ENC{shadow_d[ENC_W-1:0]}};
            enc_prog_d = '1;
          end else begin
            cnt_d = cnt_d + 1'b1;
          end
        end
      end
      KEY_PROG: begin
        if (kw_q == KW_W'(KEY_WORDS-1)) begin
          state_d    = KEY_WAIT;
          enc_prog_d = '0;
        end else begin
          kw_d       = kw_q + 1'b1;
          enc_data_d = {NUM_ENC{key_q[int'(kw_d)*ENC_W +: ENC_W]}};
        end
      end
      KEY_WAIT: begin
        if (&enc_ready) begin
          state_d      = IDLE;
          key_loaded_d = 1'b1;
        end
      end
      DATA_RX: begin
        if (!qspi_cs) begin
          state_d = IDLE;
          if (cnt_d != '0) frame_err_d = 1'b1;
          cnt_d = '0;
          pkt_d = '0;
        end else if (beat) begin
          pkt_d[int'(cnt_d)*BUS_W +: BUS_W] = qspi_data;
          if (cnt_d == CNT_W'(PKT_BEATS-1)) begin
            state_d = DATA_PUSH;
            cnt_d   = '0;
            enc_data_d[int'(idx_d)*ENC_W +: ENC_W] = pkt_d;
            enc_rot_d[int'(idx_d)*ROT_W +: ROT_W]  = rot_d;
            enc_valid_d[idx_d] = 1'b1;
          end else begin
            cnt_d = cnt_d + 1'b1;
          end
        end
      end
      DATA_PUSH: begin
        if (enc_ready[idx_q]) begin
          enc_valid_d[idx_q] = 1'b0;
          idx_d   = (idx_q == IDX_W'(NUM_ENC-1)) ? '0 : idx_q + 1'b1;
          rot_d   = (rot_q == ROT_W'(ROT_MAX-1)) ? '0 : rot_q + 1'b1;
          pkt_d   = '0;
          state_d = qspi_cs ? DATA_RX : IDLE;
        end
      end
      default: ;
    endcase

    ready_d = ((state_d == IDLE) && !err_block_d) ||
              (state_d == KEY_RX) || (state_d == DATA_RX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cs_q         <= 1'b0;
      err_block_q  <= 1'b0;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
      kw_q         <= '0;
      idx_q        <= '0;
      rot_q        <= '0;
      shadow_q     <= '0;
      key_q        <= '0;
      pkt_q        <= '0;
      enc_data_q   <= '0;
      enc_rot_q    <= '0;
      enc_prog_q   <= '0;
      enc_valid_q  <= '0;
      key_loaded_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_q         <= qspi_cs;
      err_block_q  <= err_block_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
      kw_q         <= kw_d;
      idx_q        <= idx_d;
      rot_q        <= rot_d;
      shadow_q     <= shadow_d;
      key_q        <= key_d;
      pkt_q        <= pkt_d;
      enc_data_q   <= enc_data_d;
      enc_rot_q    <= enc_rot_d;
      enc_prog_q   <= enc_prog_d;
      enc_valid_q  <= enc_valid_d;
      key_loaded_q <= key_loaded_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign qspi_ready = ready_q;
  assign enc_data   = enc_data_q;
  assign enc_rot    = enc_rot_q;
  assign enc_prog   = enc_prog_q;
  assign enc_valid  = enc_valid_q;
  assign key_loaded = key_loaded_q;
  assign frame_err  = frame_err_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_qspi_distributor.sv
// Directed bench for qspi_distributor: key load, round-robin data pushes,
// lane back-pressure, and the aborted/illegal frame cases.
module tb_qspi_distributor;
  logic         clk = 1'b0;
  logic         reset;
  logic         qspi_cs, qspi_valid, prog;
  logic [3:0]   qspi_data;
  logic         qspi_ready;
  logic [127:0] enc_data;
  logic [7:0]   enc_rot;
  logic [3:0]   enc_prog, enc_valid, enc_ready;
  logic         key_loaded, frame_err;
  logic [2:0]   state_out;

  int errors = 0;
  int checks = 0;

  qspi_distributor dut (
    .clk(clk), .reset(reset), .qspi_cs(qspi_cs), .qspi_valid(qspi_valid),
    .qspi_data(qspi_data), .qspi_ready(qspi_ready), .prog(prog),
    .enc_data(enc_data), .enc_rot(enc_rot), .enc_prog(enc_prog),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .key_loaded(key_loaded),
    .frame_err(frame_err), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] d);
    qspi_valid = 1'b1;
    qspi_data  = d;
    tick();
  endtask

  logic [31:0] pkts [5];
  logic [31:0] cur;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    pkts[0] = 32'h12345678;
    pkts[1] = 32'hCAFEBABE;
    pkts[2] = 32'hDEADBEEF;
    pkts[3] = 32'h0BADF00D;
    pkts[4] = 32'h55AA33CC;

    reset = 1'b1; qspi_cs = 1'b0; qspi_valid = 1'b0; prog = 1'b0;
    qspi_data = 4'h0; enc_ready = 4'h0;
    repeat (3) tick();
    chk("rst_state", 128'(state_out), 128'd0);
    chk("rst_ready", 128'(qspi_ready), 128'd0);
    chk("rst_data", enc_data, 128'd0);
    chk("rst_valid", 128'(enc_valid), 128'd0);
    chk("rst_keyld", 128'(key_loaded), 128'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 128'(qspi_ready), 128'd1);

    // data frame before any key
    qspi_cs = 1'b1; prog = 1'b0;
    tick();
    chk("nokey_err", 128'(frame_err), 128'd1);
    chk("nokey_state", 128'(state_out), 128'd0);
    chk("nokey_ready", 128'(qspi_ready), 128'd0);
    send_beat(4'h5);
    send_beat(4'h6);
    chk("nokey_err_off", 128'(frame_err), 128'd0);
    chk("nokey_ready_held", 128'(qspi_ready), 128'd0);
    chk("nokey_valid", 128'(enc_valid), 128'd0);
    qspi_valid = 1'b0; qspi_cs = 1'b0;
    tick();
    chk("nokey_ready_back", 128'(qspi_ready), 128'd1);

    // key frame: 32 beats of nibbles 0..F repeating
    qspi_cs = 1'b1; prog = 1'b1;
    tick();
    chk("key_rx_state", 128'(state_out), 128'd1);
    for (int k = 0; k < 32; k++) send_beat(4'(k));
    qspi_valid = 1'b0;
    chk("kp0_state", 128'(state_out), 128'd2);
    chk("kp0_prog", 128'(enc_prog), 128'hF);
    chk("kp0_ready", 128'(qspi_ready), 128'd0);
    chk("kp0_word", enc_data, {4{32'h76543210}});
    tick();
    chk("kp1_word", enc_data, {4{32'hFEDCBA98}});
    chk("kp1_prog", 128'(enc_prog), 128'hF);
    tick();
    chk("kp2_word", enc_data, {4{32'h76543210}});
    tick();
    chk("kp3_word", enc_data, {4{32'hFEDCBA98}});
    chk("kp3_prog", 128'(enc_prog), 128'hF);
    tick();
    chk("kw_state", 128'(state_out), 128'd3);
    chk("kw_prog", 128'(enc_prog), 128'd0);
    tick();
    chk("kw_hold", 128'(state_out), 128'd3);
    chk("kw_keyld", 128'(key_loaded), 128'd0);
    enc_ready = 4'hF;
    tick();
    chk("kw_exit", 128'(state_out), 128'd0);
    chk("keyld", 128'(key_loaded), 128'd1);
    qspi_cs = 1'b0; prog = 1'b0;
    tick();

    // data frame: 5 packets, lane 1 stalled for 10 cycles
    qspi_cs = 1'b1;
    tick();
    chk("drx_state", 128'(state_out), 128'd4);
    for (int p = 0; p < 5; p++) begin
      cur = pkts[p];
      enc_ready = (p == 1) ? 4'b1101 : 4'hF;
      for (int k = 0; k < 8; k++) send_beat(cur[k*4 +: 4]);
      qspi_valid = 1'b0;
      if (p == 4) qspi_cs = 1'b0;
      chk($sformatf("push%0d_state", p), 128'(state_out), 128'd5);
      chk($sformatf("push%0d_valid", p), 128'(enc_valid), 128'(4'b0001 << (p % 4)));
      chk($sformatf("push%0d_data", p), 128'(enc_data[(p%4)*32 +: 32]), 128'(cur));
      chk($sformatf("push%0d_rot", p), 128'(enc_rot[(p%4)*2 +: 2]), 128'(p % 4));
      if (p == 1) begin
        for (int s = 0; s < 10; s++) begin
          tick();
          chk("stall_valid", 128'(enc_valid), 128'h2);
          chk("stall_ready", 128'(qspi_ready), 128'd0);
          chk("stall_data", 128'(enc_data[63:32]), 128'(cur));
        end
        enc_ready = 4'hF;
      end
      tick();
      chk($sformatf("done%0d_state", p), 128'(state_out), (p == 4) ? 128'd0 : 128'd4);
      chk($sformatf("done%0d_valid", p), 128'(enc_valid), 128'd0);
    end
    chk("lane1_hold", 128'(enc_data[63:32]), 128'(pkts[1]));
    chk("lane0_last", 128'(enc_data[31:0]), 128'(pkts[4]));

    // data frame cut after 5 beats
    qspi_cs = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) send_beat(4'h9);
    qspi_valid = 1'b0; qspi_cs = 1'b0;
    tick();
    chk("cut_err", 128'(frame_err), 128'd1);
    chk("cut_state", 128'(state_out), 128'd0);
    chk("cut_valid", 128'(enc_valid), 128'd0);
    tick();
    chk("cut_err_pulse", 128'(frame_err), 128'd0);

    // key frame cut at beat 20
    qspi_cs = 1'b1; prog = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) send_beat(4'hA);
    qspi_valid = 1'b0; qspi_cs = 1'b0; prog = 1'b0;
    tick();
    chk("kcut_err", 128'(frame_err), 128'd1);
    chk("kcut_state", 128'(state_out), 128'd0);
    chk("kcut_keyld", 128'(key_loaded), 128'd1);
    chk("kcut_prog", 128'(enc_prog), 128'd0);

    // reset in the middle of a packet
    qspi_cs = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) send_beat(4'h3);
    qspi_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst_state", 128'(state_out), 128'd0);
    chk("mrst_keyld", 128'(key_loaded), 128'd0);
    chk("mrst_data", enc_data, 128'd0);
    qspi_cs = 1'b0;
    tick();
    chk("mrst_err", 128'(frame_err), 128'd0);
    reset = 1'b0;
    tick();
    chk("mrst_ready", 128'(qspi_ready), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qspi_distributor.md
QSPI_DISTRIBUTOR -- requirements
Module: qspi_distributor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_ENC, 4, number of encrypter lanes (>=1)
- BUS_W, 4, QSPI beat width (1, 2 or 4)
- ENC_W, 32, encrypter word width (multiple of BUS_W)
- KEY_W, 128, key width (multiple of ENC_W)
- ROT_MAX, 4, key-rotation modulus (>=1)
- ROT_W, 2, rotation tag width (2^ROT_W >= ROT_MAX)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- qspi_cs  in  1  frame active (level)
- qspi_valid  in  1  beat present on qspi_data
- qspi_data  in  BUS_W  beat payload
- qspi_ready  out  1  block accepts a beat this cycle
- prog  in  1  sampled on qspi_cs rise: 1 = key frame, 0 = data frame
- enc_data  out  NUM_ENC*ENC_W  per-lane word, lane i at [i*ENC_W +: ENC_W]
- enc_rot  out  NUM_ENC*ROT_W  per-lane rotation tag
- enc_prog  out  NUM_ENC  key-word strobe, all lanes
- enc_valid  out  NUM_ENC  per-lane data valid
- enc_ready  in  NUM_ENC  per-lane ready
- key_loaded  out  1  a complete key has been programmed
- frame_err  out  1  one-cycle error pulse
- state_out  out  3  current FSM state

Function
REQ-003 States SHALL be IDLE=0, KEY_RX=1, KEY_PROG=2, KEY_WAIT=3, DATA_RX=4, DATA_PUSH=5.
REQ-004 A beat SHALL transfer on a rising edge with qspi_cs & qspi_valid & qspi_ready; beats SHALL pack LSB-first (beat k -> bits [k*BUS_W +: BUS_W]).
REQ-005 In IDLE, a qspi_cs rise with prog=1 SHALL enter KEY_RX; with prog=0 and key_loaded=1 it SHALL enter DATA_RX, clearing lane index and rotation to 0.
REQ-006 A data frame start with key_loaded=0 SHALL pulse frame_err, stay IDLE, and hold qspi_ready=0 until qspi_cs falls.
REQ-007 qspi_ready SHALL be 1 only in IDLE, KEY_RX and DATA_RX.
REQ-008 KEY_RX SHALL fill a shadow key register; after KEY_W/BUS_W beats it SHALL enter KEY_PROG with no extra beats accepted.
REQ-009 KEY_PROG SHALL last KEY_W/ENC_W cycles; in cycle j every lane's enc_data SHALL carry key word j and enc_prog SHALL be all-ones; it then SHALL enter KEY_WAIT with enc_prog=0.
REQ-010 KEY_WAIT SHALL exit to IDLE on the first edge where enc_ready is all-ones, setting key_loaded=1.
REQ-011 DATA_RX SHALL collect ENC_W/BUS_W beats and then enter DATA_PUSH.
REQ-012 DATA_PUSH SHALL drive lane idx with the packet, enc_rot=rot and enc_valid[idx]=1, holding them until an edge with enc_ready[idx]=1.
REQ-013 After that transfer, idx SHALL wrap to (idx+1) mod NUM_ENC, rot SHALL wrap to (rot+1) mod ROT_MAX, and the FSM SHALL return to DATA_RX, or to IDLE if qspi_cs=0.
REQ-014 Outputs of non-target lanes SHALL hold their last values with enc_valid=0.
REQ-015 qspi_cs falling in KEY_RX SHALL discard the shadow key, keep the previous key and key_loaded, pulse frame_err, and enter IDLE.
REQ-016 qspi_cs falling in DATA_RX with a partial packet SHALL discard it and pulse frame_err; with zero beats collected it SHALL enter IDLE silently.
REQ-017 qspi_cs falling in KEY_PROG, KEY_WAIT or DATA_PUSH SHALL be ignored until that state completes.
REQ-018 A qspi_cs rise outside IDLE SHALL be ignored.

Reset
REQ-019 While reset=1, the FSM SHALL be IDLE and every output SHALL be 0, with idx, rot, beat counters, key and shadow key all 0.
REQ-020 Reset asserted mid-operation SHALL abandon any packet or key in progress with no frame_err pulse.

Verification
REQ-021 Defaults; key frame of 32 beats, nibbles 0..F repeating -> 4 KEY_PROG cycles, word0=0x76543210, enc_prog=4'hF for 4 cycles, key_loaded=1 after enc_ready=4'hF.
REQ-022 Data frame of 40 beats, enc_ready=4'hF -> 5 pushes to lanes 0,1,2,3,0 with enc_rot 0,1,2,3,0.
REQ-023 enc_ready[1]=0 for 10 cycles during lane-1 push -> enc_valid[1] held, qspi_ready=0 for those 10 cycles, data unchanged.
REQ-024 Data frame before any key -> frame_err pulse, enc_valid stays 0.
REQ-025 qspi_cs drops after 5 beats of a data packet -> frame_err pulse, no enc_valid, FSM in IDLE.
REQ-026 Key frame cut at beat 20 -> previous key and key_loaded retained, frame_err pulse.
